latch_serial_rx: RTL
====================

Name: latch_serial_rx

Overview:
- Downstream consumer of the 4-NAND D-latch stage.
- Takes the latch's q output as a serial line (idle high), synchronises it into the clk domain and frames it as start bit, WIDTH data bits LSB first, then stop bit.
- Delivers each good word on a valid/ready output port.
- First block in the lab chain with a real FSM, counters and flow control.

Parameters:
- WIDTH, 8, data bits per frame (1..16).
- BIT_CYCLES, 4, clk cycles per serial bit; even, >=2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- d  input  1  serial line from latch q; asynchronous to clk, idle = 1.
- out_data  output  WIDTH  received word; stable while out_valid=1.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer accepts the word when out_valid & out_ready at a rising edge.
- busy  output  1  1 in any state other than IDLE.
- frame_err  output  1  one-cycle pulse: stop bit sampled 0.
- overrun  output  1  one-cycle pulse: good word dropped because the output is still full.

Behaviour:
- Reset (rst_n=0, takes effect immediately):
  - state=IDLE, sync flops=1, counters=0.
  - out_data=0, out_valid=0, busy=0, frame_err=0, overrun=0.
  - Reset mid-frame discards the partial word. After release, the FSM waits for a fresh falling edge.
- Synchroniser:
  - Two flops, d -> s1 -> d_sync, both reset to 1.
  - d_sync equals d delayed by 2 rising edges. Only d_sync is used by the FSM.
- Timing reference (let H = BIT_CYCLES/2):
  - Edge S is the first edge where state=IDLE and d_sync=0.
  - Start bit is re-sampled at edge S+H.
  - Data bit i (i=0..WIDTH-1) is sampled at edge S+H+(i+1)*BIT_CYCLES.
  - Stop bit is sampled at edge S+H+(WIDTH+1)*BIT_CYCLES.
- States:
  - IDLE: on d_sync=0, go to START and clear the cycle counter.
  - START: at S+H, if d_sync=1 treat it as a glitch and return to IDLE with no output, no error. Otherwise go to DATA.
  - DATA: shift d_sync into the shift register MSB side, so the first bit ends in bit 0. After bit WIDTH-1, go to STOP.
  - STOP, d_sync=1: good frame, handled by the output rules below; go to IDLE.
  - STOP, d_sync=0: frame_err pulses high for the cycle after the sample edge; the word is discarded; go to IDLE.
  - Note: a line held low through the stop slot re-triggers START on the next edge from IDLE.
- busy: high from the cycle after edge S until the cycle after the stop sample edge.
- Output register, evaluated at the stop sample edge:
  - Good frame, out_valid=0: load out_data; out_valid=1 from the next cycle.
  - Good frame, out_valid=1 and out_ready=1: handshake and load happen on the same edge. Load the new word, out_valid stays 1, no overrun.
  - Good frame, out_valid=1 and out_ready=0: keep the old word, drop the new one, pulse overrun for one cycle.
- Handshake in any other cycle: out_valid & out_ready at an edge clears out_valid. out_data holds its last value.
- Counters:
  - Cycle counter width is clog2(BIT_CYCLES)+1 and wraps to 0 at each sample point.
  - Bit counter width is clog2(WIDTH)+1.
  - No arithmetic overflow is permitted at the maximum parameters.
- The line is not monitored between sample points. Glitches shorter than BIT_CYCLES between samples are ignored.

Test Plan:
- Reset, clean frame: WIDTH=8, BIT_CYCLES=4; reset; hold d=1 for 10 cycles, then drive frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1), 4 cycles per bit; out_ready=1 -> out_valid rises after edge S+38 with out_data=0xA5; deasserts one edge later; frame_err=overrun=0.
- Start glitch: d low for 1 cycle only -> busy high for 2 cycles, returns to IDLE, out_valid stays 0, frame_err=0.
- Framing error: send 0x3C with stop bit 0 -> frame_err high exactly 1 cycle; out_valid stays 0; next valid frame 0x81 received correctly.
- Backpressure and overrun: out_ready=0; send 0x11 then 0x22 -> out_data stays 0x11, overrun pulses once at the second stop; raise out_ready -> 0x11 consumed, out_valid=0.
- Simultaneous handshake: out_valid=1 holding 0x11; assert out_ready exactly at the stop edge of frame 0x22 -> out_data=0x22, out_valid remains 1, no overrun.
- Reset mid-frame: assert rst_n=0 during data bit 3 -> all outputs 0 immediately; after release, a full frame 0x5A is received correctly.

Source files
------------

// File: rtl/latch_serial_rx.sv
// Purpose: serial receiver for the D-latch q line; 2-flop sync, start/data/stop framing, valid/ready output.
// Latency: word appears on out_data/out_valid the cycle after the stop-bit sample edge.
// Backpressure: one-word output register; a good word arriving while full and not being consumed is dropped with an overrun pulse.
module latch_serial_rx #(
    parameter int WIDTH      = 8,
    parameter int BIT_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             d,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun
);

    localparam int CW = $clog2(BIT_CYCLES) + 1;
    localparam int BW = $clog2(WIDTH) + 1;
    localparam int H  = BIT_CYCLES / 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             s1_q;
    logic             sync_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;

    logic tick_start;
    logic tick_bit;

    // Start bit is re-checked half a bit in; later samples are one full bit apart.
    assign tick_start = (cnt_q == CW'(H - 1));
    assign tick_bit   = (cnt_q == CW'(BIT_CYCLES - 1));

    // Two-flop synchroniser for the asynchronous line; idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            s1_q   <= d;
            sync_q <= s1_q;
        end
    end

    // State, counters, shift register and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    // Next-state: framing FSM plus output-register load/handshake.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;

        // Plain handshake; a good stop below may re-set valid on the same edge.
        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (!sync_q) begin
                    state_d = START;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            START: begin
                if (tick_start) begin
                    cnt_d   = '0;
                    state_d = sync_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (tick_bit) begin
                    cnt_d   = '0;
                    // LSB arrives first: insert at the top, shift toward bit 0.
                    shift_d = (shift_q >> 1) | (WIDTH'(sync_q) << (WIDTH - 1));
                    if (bit_q == BW'(WIDTH - 1)) begin
                        bit_d   = '0;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (tick_bit) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (sync_q) begin
                        if (!valid_q || out_ready) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign busy      = (state_q != IDLE);
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

endmodule
